// File: rtl/nonzero_iterator_if.sv
// Stream bundle between the sparse-pattern producer, the nonzero iterator
// and the per-channel compute scheduler: an incoming mask stream, an
// outgoing index stream and the per-mask completion report.
interface nonzero_iterator_if #(
  parameter int N    = 16,
  parameter int LOGN = 4
);
  logic            mask_valid;
  logic            mask_ready;
  logic [N-1:0]    mask_data;
  logic            idx_valid;
  logic            idx_ready;
  logic [LOGN-1:0] idx;
  logic            idx_last;
  logic [LOGN-1:0] idx_ord;
  logic            done;
  logic [LOGN:0]   done_count;

  // Environment side: drives masks in and consumes indices.
  modport master (
    output mask_valid, mask_data, idx_ready,
    input  mask_ready, idx_valid, idx, idx_last, idx_ord, done, done_count
  );

  // Iterator side.
  modport slave (
    input  mask_valid, mask_data, idx_ready,
    output mask_ready, idx_valid, idx, idx_last, idx_ord, done, done_count
  );
endinterface

// File: rtl/nonzero_iterator.sv
// Nonzero iterator: walks an N-bit channel-activity mask and emits the
// position of every set bit, lowest first, one per index handshake, then
// reports how many indices the mask produced with a one-cycle done pulse.

// Lowest-set-bit finder used on the remaining-mask register.
module first_one #(
  parameter int N    = 16,
  parameter int LOGN = 4
) (
  input  logic [N-1:0]    vec_i,
  output logic [LOGN-1:0] addr_o,
  output logic            has_ones_o
);

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    addr_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        addr_o = LOGN'(i);
      end
    end
    has_ones_o = |vec_i;
  end

endmodule

module nonzero_iterator #(
  parameter int N    = 16,
  parameter int LOGN = 4
) (
  input  logic               clk,
  input  logic               rst,
  nonzero_iterator_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    rem_q, rem_d;
  logic [LOGN-1:0] ord_q, ord_d;
  logic            done_q, done_d;
  logic [LOGN:0]   cnt_q, cnt_d;

  logic [LOGN-1:0] firstAddr;
  logic            hasOnes;
  logic            isLast;

  first_one #(
    .N    (N),
    .LOGN (LOGN)
  ) u_first_one (
    .vec_i      (rem_q),
    .addr_o     (firstAddr),
    .has_ones_o (hasOnes)
  );

  // The current index is the last one when clearing the lowest bit empties the mask.
  assign isLast = ((rem_q & (rem_q - N'(1))) == '0);

  // State register: a reset drops any partially consumed mask without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      ord_q   <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ord_q   <= ord_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: load a mask in IDLE, peel off one bit per handshake in ITER.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ord_d   = ord_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.mask_valid) begin
          if (bus.mask_data != '0) begin
            rem_d   = bus.mask_data;
            ord_d   = '0;
            state_d = ITER;
          end else begin
            done_d = 1'b1;
            cnt_d  = '0;
          end
        end
      end
      ITER: begin
        if (bus.idx_ready) begin
          rem_d = rem_q & ~(N'(1) << firstAddr);
          ord_d = ord_q + LOGN'(1);
          if (isLast) begin
            state_d = IDLE;
            done_d  = 1'b1;
            cnt_d   = {1'b0, ord_q} + (LOGN + 1)'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs come only from registers (plus rst gating ready), so no input-to-output paths.
  always_comb begin
    bus.mask_ready = (state_q == IDLE) && !rst;
    bus.idx_valid  = (state_q == ITER);
    bus.idx        = firstAddr;
    bus.idx_last   = isLast;
    bus.idx_ord    = ord_q;
    bus.done       = done_q;
    bus.done_count = cnt_q;
  end

  // While iterating the remaining mask can never be empty.
  always_ff @(posedge clk) begin
    if (!rst && state_q == ITER) begin
      assert (hasOnes);
    end
  end

endmodule

// File: tb/tb_nonzero_iterator.sv
// Self-checking bench for nonzero_iterator: a table of masks with their
// expected index counts, plus hand-written sequences for back-pressure,
// zero masks, mid-mask reset and back-to-back masks. Every index handshake
// and done pulse is checked against a queue filled when a mask is accepted.
module tb_nonzero_iterator;

  localparam int N    = 16;
  localparam int LOGN = 4;

  typedef struct {
    logic [LOGN-1:0] idx;
    logic            last;
    logic [LOGN-1:0] ord;
  } exp_t;

  typedef struct {
    logic [N-1:0] mask;
    int           expCount;
  } vec_t;

  logic clk;
  logic rst;

  nonzero_iterator_if #(.N(N), .LOGN(LOGN)) bus ();

  nonzero_iterator #(
    .N    (N),
    .LOGN (LOGN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t idxQ[$];
  int   doneQ[$];

  logic            sIdxValid;
  logic [LOGN-1:0] sIdx;
  logic            sIdxLast;
  logic [LOGN-1:0] sIdxOrd;
  logic            sMaskReady;
  logic            sDone;
  logic [LOGN:0]   sDoneCount;
  logic            sAccepted;
  logic            doneSeen;
  int              lastDoneCount;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: expected index stream and count for an accepted mask.
  task automatic pushModel(input logic [N-1:0] mask);
    int   total;
    int   ordCnt;
    exp_t e;
    total  = 0;
    ordCnt = 0;
    for (int i = 0; i < N; i++) if (mask[i]) total++;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        e.idx  = LOGN'(i);
        e.ord  = LOGN'(ordCnt);
        e.last = (ordCnt == total - 1);
        idxQ.push_back(e);
        ordCnt++;
      end
    end
    doneQ.push_back(total);
  endtask

  // One clock: sample at the falling edge, run the scoreboard, return just after the rising edge.
  task automatic stepCycle();
    exp_t e;
    @(negedge clk);
    sIdxValid  = bus.idx_valid;
    sIdx       = bus.idx;
    sIdxLast   = bus.idx_last;
    sIdxOrd    = bus.idx_ord;
    sMaskReady = bus.mask_ready;
    sDone      = bus.done;
    sDoneCount = bus.done_count;
    sAccepted  = bus.mask_valid && bus.mask_ready;
    if (!rst) begin
      if (sAccepted) pushModel(bus.mask_data);
      if (sIdxValid) begin
        checkOutput("idxExpected", int'(idxQ.size() > 0), 1);
        if (idxQ.size() > 0) begin
          e = idxQ[0];
          checkOutput("idx", int'(sIdx), int'(e.idx));
          checkOutput("idxLast", int'(sIdxLast), int'(e.last));
          checkOutput("idxOrd", int'(sIdxOrd), int'(e.ord));
          if (bus.idx_ready) void'(idxQ.pop_front());
        end
      end
      if (sDone) begin
        doneSeen      = 1'b1;
        lastDoneCount = int'(sDoneCount);
        checkOutput("doneExpected", int'(doneQ.size() > 0), 1);
        if (doneQ.size() > 0) checkOutput("doneCount", int'(sDoneCount), doneQ.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Present a mask until it is accepted, then drop mask_valid.
  task automatic applyStimulus(input logic [N-1:0] mask);
    int n;
    n = 0;
    bus.mask_valid = 1'b1;
    bus.mask_data  = mask;
    sAccepted      = 1'b0;
    while (!sAccepted && n < 50) begin
      stepCycle();
      n++;
    end
    checkOutput("acceptInTime", int'(sAccepted), 1);
    bus.mask_valid = 1'b0;
  endtask

  task automatic waitDone(input int maxCycles);
    int n;
    n = 0;
    while (!doneSeen && n < maxCycles) begin
      stepCycle();
      n++;
    end
    checkOutput("doneInTime", int'(doneSeen), 1);
  endtask

  initial begin
    int expIdx[4];
    expIdx = '{0, 5, 10, 15};

    vecs[0] = '{16'h8421, 4};
    vecs[1] = '{16'h0000, 0};
    vecs[2] = '{16'hFFFF, 16};
    vecs[3] = '{16'h0018, 2};
    vecs[4] = '{16'h0001, 1};
    vecs[5] = '{16'h8000, 1};
    vecs[6] = '{16'h5A5A, 8};

    rst            = 1'b1;
    bus.mask_valid = 1'b0;
    bus.mask_data  = '0;
    bus.idx_ready  = 1'b1;
    doneSeen       = 1'b0;
    lastDoneCount  = -1;
    sAccepted      = 1'b0;
    repeat (3) stepCycle();
    checkOutput("readyInReset", int'(sMaskReady), 0);
    rst = 1'b0;
    stepCycle();
    checkOutput("resetIdxValid", int'(sIdxValid), 0);
    checkOutput("resetMaskReady", int'(sMaskReady), 1);
    checkOutput("resetDone", int'(sDone), 0);
    checkOutput("resetDoneCount", int'(sDoneCount), 0);

    $display("[TB] table-driven masks");
    for (int i = 0; i < 7; i++) begin
      doneSeen = 1'b0;
      applyStimulus(vecs[i].mask);
      waitDone(40);
      checkOutput("tableCount", lastDoneCount, vecs[i].expCount);
    end

    $display("[TB] 0x8421 timing");
    doneSeen = 1'b0;
    applyStimulus(16'h8421);
    for (int k = 0; k < 4; k++) begin
      stepCycle();
      checkOutput("seqValid", int'(sIdxValid), 1);
      checkOutput("seqIdx", int'(sIdx), expIdx[k]);
      checkOutput("seqLast", int'(sIdxLast), int'(k == 3));
    end
    stepCycle();
    checkOutput("seqDone", int'(sDone), 1);
    checkOutput("seqDoneCount", int'(sDoneCount), 4);
    checkOutput("seqReadyAfter", int'(sMaskReady), 1);

    $display("[TB] zero mask then immediate next mask");
    doneSeen = 1'b0;
    applyStimulus(16'h0000);
    bus.mask_valid = 1'b1;
    bus.mask_data  = 16'h0003;
    stepCycle();
    checkOutput("zeroNoValid", int'(sIdxValid), 0);
    checkOutput("zeroDone", int'(sDone), 1);
    checkOutput("zeroDoneCount", int'(sDoneCount), 0);
    checkOutput("acceptWithDone", int'(sAccepted), 1);
    bus.mask_valid = 1'b0;
    doneSeen = 1'b0;
    waitDone(20);
    checkOutput("afterZeroCount", lastDoneCount, 2);

    $display("[TB] back-pressure on 0x0018");
    doneSeen      = 1'b0;
    bus.idx_ready = 1'b0;
    applyStimulus(16'h0018);
    for (int k = 0; k < 3; k++) begin
      stepCycle();
      checkOutput("holdValid", int'(sIdxValid), 1);
      checkOutput("holdIdx", int'(sIdx), 3);
      checkOutput("holdOrd", int'(sIdxOrd), 0);
      checkOutput("holdLast", int'(sIdxLast), 0);
    end
    bus.idx_ready = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("releaseIdx", int'(sIdx), 4);
    checkOutput("releaseLast", int'(sIdxLast), 1);
    stepCycle();
    checkOutput("releaseDone", int'(sDone), 1);
    checkOutput("releaseDoneCount", int'(sDoneCount), 2);

    $display("[TB] reset in the middle of 0x00F0");
    applyStimulus(16'h00F0);
    stepCycle();
    checkOutput("preResetIdx4", int'(sIdx), 4);
    stepCycle();
    checkOutput("preResetIdx5", int'(sIdx), 5);
    rst = 1'b1;
    idxQ.delete();
    doneQ.delete();
    stepCycle();
    rst = 1'b0;
    stepCycle();
    checkOutput("postResetValid", int'(sIdxValid), 0);
    checkOutput("postResetDone", int'(sDone), 0);
    checkOutput("postResetReady", int'(sMaskReady), 1);
    doneSeen = 1'b0;
    applyStimulus(16'h0001);
    stepCycle();
    checkOutput("singleIdx", int'(sIdx), 0);
    checkOutput("singleLast", int'(sIdxLast), 1);
    waitDone(10);
    checkOutput("singleCount", lastDoneCount, 1);

    $display("[TB] back-to-back masks with mask_valid held");
    bus.mask_valid = 1'b1;
    bus.mask_data  = 16'h0003;
    sAccepted      = 1'b0;
    for (int n = 0; n < 20 && !sAccepted; n++) stepCycle();
    checkOutput("b2bFirstAccept", int'(sAccepted), 1);
    bus.mask_data = 16'h0100;
    stepCycle();
    checkOutput("b2bIdx0", int'(sIdx), 0);
    checkOutput("b2bBusyReady", int'(sMaskReady), 0);
    stepCycle();
    checkOutput("b2bIdx1", int'(sIdx), 1);
    checkOutput("b2bNoAccept", int'(sAccepted), 0);
    stepCycle();
    checkOutput("b2bBubbleValid", int'(sIdxValid), 0);
    checkOutput("b2bSecondAccept", int'(sAccepted), 1);
    bus.mask_valid = 1'b0;
    doneSeen = 1'b0;
    stepCycle();
    checkOutput("b2bIdx8Valid", int'(sIdxValid), 1);
    checkOutput("b2bIdx8", int'(sIdx), 8);
    waitDone(10);
    checkOutput("b2bCount", lastDoneCount, 1);

    repeat (3) stepCycle();
    checkOutput("leftoverIdx", idxQ.size(), 0);
    checkOutput("leftoverDone", doneQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nonzero_iterator.md
Name: nonzero_iterator

Overview:
- Downstream consumer of the first-one priority encoder.
- Accepts an N-bit channel-activity mask (a sparse nonzero pattern).
- Emits the index of every set bit in ascending order, one index per accepted handshake, on a valid/ready stream.
- Sits between the sparse-pattern producer and the per-channel compute scheduler. It instantiates first_one on its internal remaining-mask register.

Parameters:
- N, channel_num (16), mask width / number of channels; power of two, >= 4.
- LOGN, channel_num_log (4), log2(N); index width.

Ports:
- clk  input  1  single clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- mask_valid  input  1  mask_data is presented.
- mask_ready  output  1  block can accept a mask this cycle.
- mask_data  input  N  channel mask; bit i = channel i active.
- idx_valid  output  1  idx/idx_last/idx_ord are valid.
- idx_ready  input  1  downstream accepts idx this cycle.
- idx  output  LOGN  index of lowest remaining set bit.
- idx_last  output  1  idx is the final set bit of the current mask.
- idx_ord  output  LOGN  ordinal of this index within the mask (0 for the first emitted).
- done  output  1  one-cycle pulse when a mask has been fully consumed.
- done_count  output  LOGN+1  number of indices emitted for that mask; valid only while done=1.

Behaviour:
- State machine: IDLE, ITER. Registers:
  - rem[N-1:0]: remaining mask.
  - ord[LOGN-1:0]: ordinal counter.
  - done_r: done pulse.
  - cnt_r[LOGN:0]: count.
- Reset (rst sampled high at clk edge): state=IDLE, rem=0, ord=0, done=0, done_count=0. Next cycle: idx_valid=0, mask_ready=1.
- Reset mid-operation discards the remaining mask. No done pulse is produced for the aborted mask.
- mask_ready=1 only in IDLE and rst low. idx_valid=1 only in ITER.
- IDLE, mask_valid&mask_ready:
  - mask_data!=0: rem<=mask_data, ord<=0, go ITER. First idx_valid appears the next cycle (latency 1).
  - mask_data==0: stay IDLE. Next cycle done=1, done_count=0. No idx_valid ever asserted.
- ITER outputs:
  - idx = first_one(rem).addr, i.e. lowest set bit position. Combinational from the rem register.
  - idx_last = (rem & (rem-1))==0.
  - idx_ord = ord.
- ITER, idx_valid&idx_ready:
  - rem<=rem with bit idx cleared; ord<=ord+1.
  - If idx_last: go IDLE. Next cycle done=1 and done_count=ord+1 (N when all bits were set; the width LOGN+1 holds it).
- ITER, idx_ready=0: idx, idx_last, idx_ord and idx_valid held stable (AXI-style; valid never drops without a handshake).
- Throughput:
  - One index per cycle while idx_ready=1.
  - Exactly one bubble cycle (IDLE, mask_ready=1) between masks.
  - mask_valid during ITER is not accepted; the upstream holds it.
- done is a single-cycle pulse. It may coincide with acceptance of the next mask in IDLE; both take effect independently.
- The has_ones output of first_one is not needed for control (rem!=0 is guaranteed in ITER). It may be used only as an assertion check.
- No combinational path from mask_valid to idx_valid, or from idx_ready to mask_ready.

Test Plan:
- N=16, mask 0x8421, idx_ready=1 constantly:
  - idx=0,5,10,15 on 4 consecutive cycles starting 1 cycle after accept.
  - idx_ord 0..3; idx_last only with 15.
  - Next cycle done=1, done_count=4; mask_ready=1.
- Mask 0x0000 accepted:
  - idx_valid stays 0.
  - Next cycle done=1, done_count=0.
  - The following mask is accepted in the same cycle as done.
- Mask 0x0018, idx_ready low for 3 cycles after first valid:
  - idx=3, idx_ord=0, idx_last=0 held stable all 3 cycles.
  - After idx_ready rises: idx=4, idx_last=1, then done_count=2.
- Mask 0xFFFF, idx_ready=1: 16 consecutive indices 0..15; done_count=16 (5'b10000).
- Mask 0x00F0; after idx 4 and 5 are consumed, assert rst 1 cycle:
  - Next cycle idx_valid=0, done=0, mask_ready=1.
  - Then mask 0x0001 gives idx=0, idx_last=1, done_count=1.
- mask_valid held high with 0x0003 then 0x0100 back-to-back:
  - Second mask not accepted until 1 cycle after idx=1 handshake.
  - Output sequence 0,1,(bubble),8.
